cam_match_iterator: RTL and testbench

//  Sequential multi-match priority encoder for the CAM search path. It accepts one

---
 rtl/cam_match_iterator.sv | 103 ++++++++++
 tb/tb_cam_match_iterator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cam_match_iterator.sv
// Sequential multi-match priority encoder: accepts one match vector, then emits the
// index of every set bit, one per output handshake, in priority order.
module cam_match_iterator #(
  parameter int unsigned WIDTH        = 8,
  parameter string       LSB_PRIORITY = "HIGH",
  localparam int unsigned IDX_W       = $clog2(WIDTH),
  localparam int unsigned CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_vector,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [IDX_W-1:0] m_index,
  output logic             m_match,
  output logic             m_last,
  output logic [CNT_W-1:0] m_count,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             abort
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ITER = 1'b1;

  localparam bit LsbFirst = (LSB_PRIORITY != "LOW");

  logic [0:0]       state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_clr;
  logic [CNT_W-1:0] load_count;
  logic [IDX_W-1:0] enc_index;
  logic             found;
  logic             at_most_one;

  always_comb begin
    load_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_count = load_count + CNT_W'(s_vector[i]);
    end
  end

  always_comb begin
    enc_index = '0;
    found     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LsbFirst) begin
        if (!found && pending[i]) begin
          enc_index = IDX_W'(i);
          found     = 1'b1;
        end
      end else begin
        if (!found && pending[WIDTH-1-i]) begin
          enc_index = IDX_W'(WIDTH - 1 - i);
          found     = 1'b1;
        end
      end
    end
  end

  // Population <= 1 iff clearing the lowest set bit leaves nothing.
  assign at_most_one = ((pending & (pending - WIDTH'(1))) == '0);
  assign pending_clr = pending & ~(WIDTH'(1) << enc_index);

  // pending is always zero in IDLE, so index and match fall back to their reset values.
  assign s_ready = (state == IDLE);
  assign m_valid = (state == ITER);
  assign m_index = enc_index;
  assign m_match = |pending;
  assign m_last  = (state == ITER) && at_most_one;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      m_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            state   <= ITER;
            pending <= s_vector;
            m_count <= load_count;
          end
        end
        ITER: begin
          if (abort) begin
            state   <= IDLE;
            pending <= '0;
          end else if (m_ready) begin
            pending <= pending_clr;
            if (at_most_one) state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_match_iterator.sv
// Directed bench: three iterators (8-bit lsb-first, 8-bit msb-first, 5-bit lsb-first).
module tb_cam_match_iterator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_vec   [3];
  logic       s_valid [3];
  logic       m_ready [3];
  logic       abort   [3];

  logic       o_sready [3];
  logic       o_valid  [3];
  logic       o_match  [3];
  logic       o_last   [3];
  logic [7:0] o_idx    [3];
  logic [7:0] o_cnt    [3];

  logic [2:0] idx0, idx1, idx2;
  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;

  assign o_idx[0] = {5'd0, idx0};
  assign o_idx[1] = {5'd0, idx1};
  assign o_idx[2] = {5'd0, idx2};
  assign o_cnt[0] = {4'd0, cnt0};
  assign o_cnt[1] = {4'd0, cnt1};
  assign o_cnt[2] = {5'd0, cnt2};

  cam_match_iterator #(.WIDTH(8), .LSB_PRIORITY("HIGH")) u_hi (
    .clk(clk), .rst(rst), .s_vector(s_vec[0]), .s_valid(s_valid[0]), .s_ready(o_sready[0]),
    .m_index(idx0), .m_match(o_match[0]), .m_last(o_last[0]), .m_count(cnt0),
    .m_valid(o_valid[0]), .m_ready(m_ready[0]), .abort(abort[0])
  );

  cam_match_iterator #(.WIDTH(8), .LSB_PRIORITY("LOW")) u_lo (
    .clk(clk), .rst(rst), .s_vector(s_vec[1]), .s_valid(s_valid[1]), .s_ready(o_sready[1]),
    .m_index(idx1), .m_match(o_match[1]), .m_last(o_last[1]), .m_count(cnt1),
    .m_valid(o_valid[1]), .m_ready(m_ready[1]), .abort(abort[1])
  );

  cam_match_iterator #(.WIDTH(5), .LSB_PRIORITY("HIGH")) u_w5 (
    .clk(clk), .rst(rst), .s_vector(s_vec[2][4:0]), .s_valid(s_valid[2]),
    .s_ready(o_sready[2]), .m_index(idx2), .m_match(o_match[2]), .m_last(o_last[2]),
    .m_count(cnt2), .m_valid(o_valid[2]), .m_ready(m_ready[2]), .abort(abort[2])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int d, input logic [7:0] v);
    check($sformatf("d%0d s_ready before load", d), 32'(o_sready[d]), 1);
    s_vec[d]   = v;
    s_valid[d] = 1'b1;
    step();
    s_valid[d] = 1'b0;
  endtask

  // Consume n beats with m_ready held high; e[] gives expected indices in order.
  task automatic drain(input int d, input int n, input int e[8], input int cnt);
    m_ready[d] = 1'b1;
    for (int k = 0; k < n; k++) begin
      check($sformatf("d%0d beat%0d valid", d, k), 32'(o_valid[d]), 1);
      check($sformatf("d%0d beat%0d index", d, k), 32'(o_idx[d]), e[k]);
      check($sformatf("d%0d beat%0d match", d, k), 32'(o_match[d]), (cnt != 0) ? 1 : 0);
      check($sformatf("d%0d beat%0d last", d, k), 32'(o_last[d]), (k == n - 1) ? 1 : 0);
      check($sformatf("d%0d beat%0d count", d, k), 32'(o_cnt[d]), cnt);
      step();
    end
    m_ready[d] = 1'b0;
    check($sformatf("d%0d idle valid", d), 32'(o_valid[d]), 0);
    check($sformatf("d%0d idle s_ready", d), 32'(o_sready[d]), 1);
  endtask

  initial begin
    logic [7:0] snap_idx;
    logic [7:0] snap_cnt;
    logic       snap_last;
    for (int d = 0; d < 3; d++) begin
      s_vec[d] = '0; s_valid[d] = 1'b0; m_ready[d] = 1'b0; abort[d] = 1'b0;
    end
    step();
    step();
    rst = 1'b0;

    check("reset s_ready", 32'(o_sready[0]), 1);
    check("reset m_valid", 32'(o_valid[0]), 0);
    check("reset m_index", 32'(o_idx[0]), 0);
    check("reset m_match", 32'(o_match[0]), 0);
    check("reset m_last", 32'(o_last[0]), 0);
    check("reset m_count", 32'(o_cnt[0]), 0);

    // 1: lsb-first order
    load(0, 8'b1001_0110);
    drain(0, 4, '{1, 2, 4, 7, 0, 0, 0, 0}, 4);

    // 2: msb-first order
    load(1, 8'b1001_0110);
    drain(1, 4, '{7, 4, 2, 1, 0, 0, 0, 0}, 4);

    // 3: zero vector gives one no-match last beat
    load(0, 8'h00);
    drain(0, 1, '{0, 0, 0, 0, 0, 0, 0, 0}, 0);

    // 4: all ones with m_ready toggling; extra s_valid must be ignored mid-vector
    load(0, 8'hFF);
    s_vec[0]   = 8'h01;
    s_valid[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m_ready[0] = 1'b0;
      snap_idx   = o_idx[0];
      snap_cnt   = o_cnt[0];
      snap_last  = o_last[0];
      check($sformatf("ff beat%0d index", k), 32'(snap_idx), k);
      check($sformatf("ff beat%0d s_ready", k), 32'(o_sready[0]), 0);
      step();
      check($sformatf("ff stall%0d index", k), 32'(o_idx[0]), 32'(snap_idx));
      check($sformatf("ff stall%0d count", k), 32'(o_cnt[0]), 32'(snap_cnt));
      check($sformatf("ff stall%0d last", k), 32'(o_last[0]), 32'(snap_last));
      check($sformatf("ff stall%0d valid", k), 32'(o_valid[0]), 1);
      check($sformatf("ff stall%0d last exp", k), 32'(o_last[0]), (k == 7) ? 1 : 0);
      m_ready[0] = 1'b1;
      step();
    end
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b0;
    check("ff done valid", 32'(o_valid[0]), 0);
    check("ff done s_ready", 32'(o_sready[0]), 1);

    // 5: abort on the first beat, then a single-hit vector
    load(0, 8'b1110_0000);
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;
    check("abort valid", 32'(o_valid[0]), 0);
    check("abort s_ready", 32'(o_sready[0]), 1);
    check("abort index", 32'(o_idx[0]), 0);
    load(0, 8'b0000_0001);
    drain(0, 1, '{0, 0, 0, 0, 0, 0, 0, 0}, 1);

    // abort in IDLE does not block a load; abort with m_ready on the last beat ends it
    abort[0] = 1'b1;
    load(0, 8'b0000_1000);
    check("idle abort accepted", 32'(o_valid[0]), 1);
    check("idle abort index", 32'(o_idx[0]), 3);
    m_ready[0] = 1'b1;
    step();
    abort[0]   = 1'b0;
    m_ready[0] = 1'b0;
    check("abort+ready valid", 32'(o_valid[0]), 0);
    check("abort+ready s_ready", 32'(o_sready[0]), 1);

    // 6: reset mid-iteration
    load(0, 8'hA5);
    m_ready[0] = 1'b1;
    step();
    step();
    m_ready[0] = 1'b0;
    check("a5 third index", 32'(o_idx[0]), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst s_ready", 32'(o_sready[0]), 1);
    check("rst m_valid", 32'(o_valid[0]), 0);
    check("rst m_index", 32'(o_idx[0]), 0);
    check("rst m_match", 32'(o_match[0]), 0);
    check("rst m_last", 32'(o_last[0]), 0);
    check("rst m_count", 32'(o_cnt[0]), 0);
    load(0, 8'h03);
    drain(0, 2, '{0, 1, 0, 0, 0, 0, 0, 0}, 2);

    // non-power-of-two width
    load(2, 8'b0001_0001);
    drain(2, 2, '{0, 4, 0, 0, 0, 0, 0, 0}, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
